// File: rtl/ctrl_pkg.sv
// Shared control-path types for the systolic-array controllers.
// Contents:
//   wfill_state_t - state encoding of weight_fill_ctrl
package ctrl_pkg;

    typedef enum logic [2:0] {
        WF_IDLE,
        WF_PAD,
        WF_FETCH,
        WF_DRAIN,
        WF_COMMIT,
        WF_DONE
    } wfill_state_t;

endpackage

// File: rtl/weight_fill_ctrl.sv
// Weight tile loader: performs exactly ARRAY_DIM shifts into the systolic array's weight
// shift chain (zero padding first, then num_row rows popped from the weight FIFO), commits
// the chain into the active weight registers, then pulses fill_done back to compute_ctrl.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   start          1-cycle request from compute_ctrl; accepted only in IDLE
//   num_row        rows to load, clamped to ARRAY_DIM; sampled when start is accepted
//   fifo_empty     weight FIFO empty flag
//   fifo_rd_en     FIFO pop; data arrives on fifo_rd_data the following cycle
//   fifo_rd_data   one weight row from the FIFO
//   w_shift        advance the weight shift chain this cycle
//   w_data         row entering the chain (zero while padding)
//   w_commit       1-cycle pulse: copy shift chain into active weights
//   fill_done      1-cycle pulse, the cycle after w_commit
//   busy           fill in progress
//   start_err      sticky flag: start seen while not IDLE; cleared only by rst
module weight_fill_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ARRAY_DIM  = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [DATA_WIDTH-1:0]           num_row,
    input  logic                            fifo_empty,
    output logic                            fifo_rd_en,
    input  logic [ARRAY_DIM*DATA_WIDTH-1:0] fifo_rd_data,
    output logic                            w_shift,
    output logic [ARRAY_DIM*DATA_WIDTH-1:0] w_data,
    output logic                            w_commit,
    output logic                            fill_done,
    output logic                            busy,
    output logic                            start_err
);

    localparam int unsigned ROW_W = $clog2(ARRAY_DIM + 1);
    localparam logic [ROW_W-1:0] DimRows = ROW_W'(ARRAY_DIM);
    localparam logic [ROW_W-1:0] OneRow  = ROW_W'(1);

    wfill_state_t     state_q, state_d;
    logic [ROW_W-1:0] n_q, n_d;        // clamped row count of the current tile
    logic [ROW_W-1:0] cnt_q, cnt_d;    // pad cycles in PAD, issued reads in FETCH
    logic             rd_vld_q;        // FIFO data valid this cycle
    logic             start_err_q, start_err_d;
    logic             pad_shift;
    logic [ROW_W-1:0] n_start;

    // Upper num_row bits only matter for the clamp comparison.
    assign n_start = (num_row > DATA_WIDTH'(ARRAY_DIM)) ? DimRows : num_row[ROW_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= WF_IDLE;
            n_q         <= '0;
            cnt_q       <= '0;
            rd_vld_q    <= 1'b0;
            start_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            cnt_q       <= cnt_d;
            rd_vld_q    <= fifo_rd_en;
            start_err_q <= start_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        cnt_d       = cnt_q;
        fifo_rd_en  = 1'b0;
        pad_shift   = 1'b0;
        w_commit    = 1'b0;
        fill_done   = 1'b0;
        start_err_d = start_err_q | (start & (state_q != WF_IDLE));

        unique case (state_q)
            WF_IDLE: begin
                if (start) begin
                    n_d     = n_start;
                    cnt_d   = '0;
                    state_d = (n_start == DimRows) ? WF_FETCH : WF_PAD;
                end
            end
            WF_PAD: begin
                pad_shift = 1'b1;
                if (cnt_q == DimRows - n_q - OneRow) begin
                    cnt_d   = '0;
                    state_d = (n_q != '0) ? WF_FETCH : WF_COMMIT;
                end else begin
                    cnt_d = cnt_q + OneRow;
                end
            end
            WF_FETCH: begin
                fifo_rd_en = !fifo_empty;
                if (!fifo_empty) begin
                    if (cnt_q == n_q - OneRow) begin
                        cnt_d   = '0;
                        state_d = WF_DRAIN;
                    end else begin
                        cnt_d = cnt_q + OneRow;
                    end
                end
            end
            // Last read's data is shifted in here via rd_vld_q.
            WF_DRAIN:  state_d = WF_COMMIT;
            WF_COMMIT: begin
                w_commit = 1'b1;
                state_d  = WF_DONE;
            end
            WF_DONE: begin
                fill_done = 1'b1;
                state_d   = WF_IDLE;
            end
            default:   state_d = WF_IDLE;
        endcase
    end

    // PAD always precedes the first read, so the two shift sources never overlap.
    assign w_shift   = pad_shift | rd_vld_q;
    assign w_data    = rd_vld_q ? fifo_rd_data : '0;
    assign busy      = (state_q != WF_IDLE);
    assign start_err = start_err_q;

endmodule

// File: tb/tb_weight_fill_ctrl.sv
// Self-checking bench for weight_fill_ctrl (ARRAY_DIM=8, DATA_WIDTH=16).
module tb_weight_fill_ctrl;

    localparam int unsigned DW = 16;
    localparam int unsigned AD = 8;
    localparam int unsigned WW = AD * DW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [DW-1:0] num_row = '0;
    logic          fifo_empty = 1'b0;
    logic          fifo_rd_en;
    logic [WW-1:0] fifo_rd_data = '0;
    logic          w_shift;
    logic [WW-1:0] w_data;
    logic          w_commit;
    logic          fill_done;
    logic          busy;
    logic          start_err;

    int            n_checks = 0;
    int            n_errors = 0;
    bit            exp_err  = 1'b0;
    logic [WW-1:0] fifo_q[$];
    logic [WW-1:0] chain[AD];

    always #5 clk = ~clk;

    weight_fill_ctrl #(.DATA_WIDTH(DW), .ARRAY_DIM(AD)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .num_row      (num_row),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .w_shift      (w_shift),
        .w_data       (w_data),
        .w_commit     (w_commit),
        .fill_done    (fill_done),
        .busy         (busy),
        .start_err    (start_err)
    );

    function automatic logic [WW-1:0] rand_word();
        logic [WW-1:0] w;
        for (int i = 0; i < AD; i++) w[i*DW +: DW] = DW'($urandom);
        if (w == '0) w[0] = 1'b1;
        return w;
    endfunction

    // One fill: start sampled at edge 0, fifo_empty forced high in cycles stall_lo..stall_hi,
    // an extra start pulse in cycle err_at (0: none, -1: the DONE cycle).
    task automatic run_fill(input int nrow, input int stall_lo, input int stall_hi,
                            input int err_at, input string name);
        int            n, p, k, last_rd, commit_c, done_c, err_c;
        bit            e_rd[64];
        bit            e_shift[64];
        logic [WW-1:0] e_data[64];
        logic [WW-1:0] tile[AD];
        logic [WW-1:0] words[$];
        bit            rd_seen;
        n = (nrow > AD) ? AD : nrow;
        p = AD - n;
        for (int i = 0; i < 64; i++) begin
            e_rd[i] = 0; e_shift[i] = 0; e_data[i] = '0;
        end
        for (int r = 0; r < AD; r++) tile[r] = rand_word();
        // FIFO holds tile rows descending; one spare word exposes any over-read.
        words = {};
        for (int r = n - 1; r >= 0; r--) words.push_back(tile[r]);
        fifo_q = words;
        fifo_q.push_back(rand_word());
        for (int c = 1; c <= p; c++) e_shift[c] = 1;
        k = 0;
        last_rd = 0;
        for (int c = p + 1; k < n; c++) begin
            if (!(c >= stall_lo && c <= stall_hi)) begin
                e_rd[c] = 1;
                e_shift[c+1] = 1;
                e_data[c+1] = words[k];
                k++;
                last_rd = c;
            end
        end
        commit_c = (n == 0) ? p + 1 : last_rd + 2;
        done_c   = commit_c + 1;
        err_c    = (err_at < 0) ? done_c : err_at;
        for (int r = 0; r < AD; r++) chain[r] = '0;

        @(negedge clk);
        start   = 1'b1;
        num_row = DW'(nrow);
        @(posedge clk);
        #1;
        start   = 1'b0;
        num_row = DW'($urandom);
        for (int cyc = 1; cyc <= done_c + 1; cyc++) begin
            fifo_empty = (cyc >= stall_lo && cyc <= stall_hi);
            if (cyc == err_c) begin
                start   = 1'b1;
                num_row = DW'($urandom_range(0, AD));
            end
            @(negedge clk);
            n_checks += 6;
            if (fifo_rd_en !== e_rd[cyc]) begin
                n_errors++;
                $display("FAIL %s c%0d fifo_rd_en got %b exp %b", name, cyc, fifo_rd_en,
                         e_rd[cyc]);
            end
            if (w_shift !== e_shift[cyc]) begin
                n_errors++;
                $display("FAIL %s c%0d w_shift got %b exp %b", name, cyc, w_shift, e_shift[cyc]);
            end
            if (w_commit !== (cyc == commit_c)) begin
                n_errors++;
                $display("FAIL %s c%0d w_commit got %b exp %b", name, cyc, w_commit,
                         cyc == commit_c);
            end
            if (fill_done !== (cyc == done_c)) begin
                n_errors++;
                $display("FAIL %s c%0d fill_done got %b exp %b", name, cyc, fill_done,
                         cyc == done_c);
            end
            if (busy !== (cyc <= done_c)) begin
                n_errors++;
                $display("FAIL %s c%0d busy got %b exp %b", name, cyc, busy, cyc <= done_c);
            end
            if (start_err !== exp_err) begin
                n_errors++;
                $display("FAIL %s c%0d start_err got %b exp %b", name, cyc, start_err, exp_err);
            end
            if (e_shift[cyc]) begin
                n_checks++;
                if (w_data !== e_data[cyc]) begin
                    n_errors++;
                    $display("FAIL %s c%0d w_data got %h exp %h", name, cyc, w_data,
                             e_data[cyc]);
                end
            end
            // Committed rows must equal the tile, zero above row N-1.
            if (w_commit === 1'b1) begin
                for (int r = 0; r < AD; r++) begin
                    n_checks++;
                    if (chain[r] !== ((r < n) ? tile[r] : '0)) begin
                        n_errors++;
                        $display("FAIL %s commit row%0d got %h exp %h", name, r, chain[r],
                                 (r < n) ? tile[r] : '0);
                    end
                end
            end
            if (w_shift === 1'b1) begin
                for (int r = AD - 1; r > 0; r--) chain[r] = chain[r-1];
                chain[0] = w_data;
            end
            rd_seen = (fifo_rd_en === 1'b1);
            @(posedge clk);
            if (rd_seen && fifo_q.size() > 0) fifo_rd_data = fifo_q.pop_front();
            if (cyc == err_c) exp_err = 1'b1;
            #1;
            start = 1'b0;
        end
        fifo_empty = 1'b0;
    endtask

    task automatic test_reset();
        fifo_rd_data = rand_word();
        rst = 1'b1;
        #12;
        n_checks += 7;
        if ({fifo_rd_en, w_shift, w_commit, fill_done, busy, start_err} !== 6'b0) begin
            n_errors++;
            $display("FAIL reset flags got %b exp 000000",
                     {fifo_rd_en, w_shift, w_commit, fill_done, busy, start_err});
        end
        if (w_data !== '0) begin
            n_errors++;
            $display("FAIL reset w_data got %h exp 0", w_data);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_err = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fixed();
        run_fill(8, 0, -1, 0, "full");
        run_fill(3, 0, -1, 0, "partial3");
        run_fill(0, 0, -1, 0, "zero");
        run_fill(20, 0, -1, 0, "clamp20");
        run_fill(4, 6, 8, 0, "stall4");
    endtask

    task automatic test_random();
        int nr, lo;
        for (int it = 0; it < 10; it++) begin
            nr = (it % 4 == 3) ? int'($urandom_range(9, 65535)) : int'($urandom_range(0, AD));
            lo = $urandom_range(1, 10);
            run_fill(nr, lo, lo + int'($urandom_range(0, 3)), 0, "random");
        end
    endtask

    task automatic test_back_to_back();
        run_fill(5, 0, -1, 0, "b2b_a");
        run_fill(2, 0, -1, 0, "b2b_b");
    endtask

    task automatic test_start_err();
        run_fill(6, 0, -1, 3, "start_busy");
        run_fill(2, 0, -1, -1, "start_done");
    endtask

    task automatic test_rst_mid();
        fifo_q = {};
        for (int i = 0; i <= AD; i++) fifo_q.push_back(rand_word());
        @(negedge clk);
        start   = 1'b1;
        num_row = DW'(AD);
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int cyc = 1; cyc < 5; cyc++) begin
            @(posedge clk);
            if (fifo_rd_en === 1'b1 && fifo_q.size() > 0) fifo_rd_data = fifo_q.pop_front();
        end
        #1;
        n_checks += 2;
        if (w_shift !== 1'b1 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL rst_mid pre w_shift/busy got %b%b exp 11", w_shift, busy);
        end
        rst = 1'b1;
        #1;
        if ({fifo_rd_en, w_shift, w_commit, fill_done, busy, start_err, |w_data} !== 7'b0) begin
            n_errors++;
            $display("FAIL rst_mid outputs got %b exp 0000000",
                     {fifo_rd_en, w_shift, w_commit, fill_done, busy, start_err, |w_data});
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_err = 1'b0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            n_checks++;
            if (fill_done !== 1'b0 || w_commit !== 1'b0 || busy !== 1'b0) begin
                n_errors++;
                $display("FAIL rst_mid after c%0d done/commit/busy got %b%b%b exp 000", cyc,
                         fill_done, w_commit, busy);
            end
        end
    endtask

    task automatic test_after_rst();
        run_fill(8, 0, -1, 0, "after_rst");
        run_fill(3, 4, 7, 0, "after_rst_stall");
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_random();
        test_back_to_back();
        test_start_err();
        test_rst_mid();
        test_after_rst();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
